bundle_packer: RTL and testbench
================================

Name: bundle_packer

Overview:
- Issue-side encoder that packs a stream of single decoded instructions into 60-bit dual-issue fetch bundles.
- Its output is exactly the format the front-end parser splits back into two instruction lanes.
- Sits between the instruction source (assembler-loader / test feeder) and instruction memory or the parser input.
- Pairs instructions, chooses the slot-2 position from slot-1 format, and pads with a NOP on timeout or flush.

Parameters:
- FLUSH_TIMEOUT, 8: idle cycles with a lone held instruction before auto-pad; 0 disables the timeout.
- NOP_OPCODE, 7'h00: opcode placed in a padded slot 2.

Ports:
- clock_i  in  1  single clock, rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- instr_valid_i  in  1  input instruction valid
- instr_ready_o  out  1  packer accepts an instruction this cycle
- isBranch_i  in  1  branch bit
- instructionFormat_i  in  1  0 = 19b (5-bit register operand), 1 = 30b (16-bit immediate)
- opcode_i  in  7  opcode
- reg_i  in  5  first register operand
- operand_i  in  16  operand; only [4:0] is used when format = 0
- flush_i  in  1  force-close a half-filled bundle
- bundle_o  out  60  packed bundle
- bundle_valid_o  out  1  bundle_o valid
- bundle_ready_i  in  1  downstream takes the bundle; tie to 1 for the parser, which has no backpressure

Behaviour:
- Reset (async, reset_n_i = 0):
  - hold slot empty, output register empty, timeout counter 0.
  - bundle_valid_o = 0, bundle_o = 0.
  - Any bundle in flight is discarded.
- Transfers:
  - Accept = instr_valid_i & instr_ready_o.
  - Emit = bundle_valid_o & bundle_ready_i.
- Ready rule (combinational): instr_ready_o = !hold_valid | !bundle_valid_o | bundle_ready_i.
- States, held as hold_valid plus out_valid:
  - EMPTY: accept stores the instruction in the hold slot, go to HALF.
  - HALF: accept forms {held, new} into the output register next edge, hold clears, go to EMPTY/OUT. bundle_valid_o rises the cycle after the second accept.
  - OUT: bundle_o and bundle_valid_o are stable until emit. A new accept may fill the hold slot concurrently.
- Bundle layout:
  - Slot 1 is always [59] fmt, [58] branch, [57:51] opcode, [50:46] reg.
  - If slot-1 fmt = 1:
    - [45:30] = operand
    - [29] = fmt2, [28] = br2, [27:21] = op2, [20:16] = reg2, [15:0] = operand2
  - If slot-1 fmt = 0:
    - [45:41] = operand[4:0]
    - [40] = fmt2, [39] = br2, [38:32] = op2, [31:27] = reg2, [26:11] = operand2
    - [10:0] = 0
- Width rules:
  - A 19b-format operand placed in a 16-bit slot-2 field is zero-extended from operand[4:0].
  - operand_i[15:5] is ignored for format 0.
- Pad (close a HALF bundle with slot 2 = fmt 0, br 0, NOP_OPCODE, reg 0, operand 0):
  - Triggered by flush_i = 1 while HALF, or the timeout counter reaching FLUSH_TIMEOUT.
  - Happens only when the output register is free or draining this cycle; otherwise the pad waits and the counter saturates.
- Timeout counter: increments each HALF cycle without an accept, and clears on accept, on pad, or when not HALF.
- Simultaneous events:
  - Accept in HALF on the same cycle as flush or timeout: the accept wins and pairs normally; the flush is consumed.
  - flush_i while EMPTY: no effect.
- Back-to-back: throughput is one instruction per cycle and one bundle per 2 cycles with bundle_ready_i = 1. There are no bubbles and no reordering; slot 1 is always the older instruction.

Optional Feature:
- Macro: BUNDLE_BRANCH_CLOSE_EN.
- Defined:
  - An instruction accepted in EMPTY with isBranch_i = 1 is never held.
  - It goes straight to the output register padded with a NOP slot 2; bundle_valid_o rises the next cycle.
  - Timing: same as a pad. While the output is stalled it occupies the hold slot, and the pad fires as soon as the output register frees.
- Undefined: branches pair like any other instruction.

Test Plan:
- A (fmt1, br0, op 7'h12, reg 3, op 16'hBEEF) then B (fmt0, br1, op 7'h05, reg 7, op 5'd9) -> one cycle later bundle: [59]=1, [57:51]=12h, [50:46]=3, [45:30]=BEEF, [29]=0, [28]=1, [27:21]=05h, [20:16]=7, [15:0]=0009h.
- A (fmt0, op 7'h01, reg 2, op 5'd4) then B (fmt1, op 7'h7F, reg 31, op 16'h1234) -> [45:41]=4, [40]=1, [38:32]=7Fh, [31:27]=31, [26:11]=1234h, [10:0]=0.
- Single instruction, no follow-up, FLUSH_TIMEOUT = 8 -> padded bundle after 8 idle cycles, slot-2 opcode = NOP_OPCODE; flush_i at cycle 3 instead -> pad the next cycle.
- bundle_ready_i = 0 with 4 instructions streamed -> first bundle held stable, third instruction held, instr_ready_o = 0 for the fourth; release ready -> bundles emitted in order.
- reset_n_i low mid-HALF and mid-OUT -> bundle_valid_o = 0 immediately (async); no stale bundle after release.
- Macro defined: branch instruction from EMPTY -> padded bundle next cycle; macro undefined: same stimulus -> held and paired with the next instruction.

Source files
------------

// File: rtl/bundle_packer.sv
// bundle_packer: pairs single decoded instructions into 60-bit dual-issue bundles, padding with a NOP on flush or timeout.
// Optional BUNDLE_BRANCH_CLOSE_EN: a branch accepted with no partner closes its own bundle with a NOP slot 2.
module bundle_packer #(
    parameter int         FLUSH_TIMEOUT = 8,
    parameter logic [6:0] NOP_OPCODE    = 7'h00
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic        isBranch_i,
    input  logic        instructionFormat_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  reg_i,
    input  logic [15:0] operand_i,
    input  logic        flush_i,
    output logic [59:0] bundle_o,
    output logic        bundle_valid_o,
    input  logic        bundle_ready_i
);
    // state    | meaning
    // ST_EMPTY | hold slot free
    // ST_HALF  | one instruction held, waiting for a partner or a pad
    // (the output register's OUT condition is tracked separately by out_valid)
    typedef enum logic {ST_EMPTY, ST_HALF} state_t;

    typedef struct packed {
        logic        fmt;
        logic        br;
        logic [6:0]  op;
        logic [4:0]  rg;
        logic [15:0] opnd;
    } slot_t;

    localparam int CW = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX  = CW'(FLUSH_TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);
    localparam slot_t NOP_SLOT = slot_t'({2'b00, NOP_OPCODE, 21'd0});

    state_t          state, state_nxt;
    slot_t           hold, hold_nxt, in_slot;
    logic [59:0]     out_bundle, out_nxt;
    logic            out_valid, ov_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic            flush_pend, fp_nxt;
    logic            out_free, accept, timeout_hit, load, close_branch, in_branch;

    function automatic logic [59:0] pack_bundle(input slot_t s1, input slot_t s2);
        logic [59:0] r;
        if (s1.fmt)
            r = {s1, s2};
        else
            r = {s1.fmt, s1.br, s1.op, s1.rg, s1.opnd[4:0], s2, 11'd0};
        return r;
    endfunction

    // Format-0 operands are zero-extended from [4:0] at capture time.
    assign in_slot = {instructionFormat_i, isBranch_i, opcode_i, reg_i,
                      instructionFormat_i ? operand_i : {11'd0, operand_i[4:0]}};

    assign out_free      = !out_valid || bundle_ready_i;
    assign instr_ready_o = (state == ST_EMPTY) || out_free;
    assign accept        = instr_valid_i && instr_ready_o;
    assign timeout_hit   = (FLUSH_TIMEOUT != 0) && (cnt >= TO_LAST);
    assign cnt_inc       = (cnt == TO_MAX) ? cnt : cnt + 1'b1;

`ifdef BUNDLE_BRANCH_CLOSE_EN
    assign close_branch = hold.br;
    assign in_branch    = isBranch_i;
`else
    assign close_branch = 1'b0;
    assign in_branch    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        out_nxt   = out_bundle;
        ov_nxt    = out_valid && !bundle_ready_i;
        load      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    if (in_branch && out_free) begin
                        out_nxt = pack_bundle(in_slot, NOP_SLOT);
                        ov_nxt  = 1'b1;
                    end else begin
                        hold_nxt  = in_slot;
                        state_nxt = ST_HALF;
                    end
                end
            end
            ST_HALF: begin
                // A held branch closes first; a concurrent accept simply refills the hold slot.
                if (close_branch && out_free) begin
                    out_nxt = pack_bundle(hold, NOP_SLOT);
                    ov_nxt  = 1'b1;
                    load    = 1'b1;
                    if (accept)
                        hold_nxt = in_slot;
                    else
                        state_nxt = ST_EMPTY;
                end else if (accept) begin
                    out_nxt   = pack_bundle(hold, in_slot);
                    ov_nxt    = 1'b1;
                    load      = 1'b1;
                    state_nxt = ST_EMPTY;
                end else if ((flush_i || flush_pend || timeout_hit) && out_free) begin
                    out_nxt   = pack_bundle(hold, NOP_SLOT);
                    ov_nxt    = 1'b1;
                    load      = 1'b1;
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        cnt_nxt = (state == ST_HALF && !load) ? cnt_inc : '0;
        fp_nxt  = (state == ST_HALF && !load) ? (flush_pend || flush_i) : 1'b0;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= ST_EMPTY;
            hold       <= '0;
            out_bundle <= '0;
            out_valid  <= 1'b0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold       <= hold_nxt;
            out_bundle <= out_nxt;
            out_valid  <= ov_nxt;
            cnt        <= cnt_nxt;
            flush_pend <= fp_nxt;
        end
    end

    assign bundle_o       = out_bundle;
    assign bundle_valid_o = out_valid;

endmodule

// File: tb/tb_bundle_packer.sv
// Scoreboard bench for bundle_packer: stimulus pushes expected bundles, a negedge monitor pops on every emit.
module tb_bundle_packer;
    logic        clock = 1'b0, reset_n = 1'b0;
    logic        instr_valid = 1'b0, is_branch = 1'b0, fmt = 1'b0, flush = 1'b0, bundle_ready = 1'b1;
    logic [6:0]  opcode = '0;
    logic [4:0]  rg = '0;
    logic [15:0] operand = '0;
    logic        instr_ready, bundle_valid;
    logic [59:0] bundle;
    int total = 0, bad = 0, cyc = 0;

    typedef struct {logic [59:0] b; int c;} exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic f; logic br; logic [6:0] op; logic [4:0] rg; logic [15:0] opnd;
    } ins_t;

    localparam ins_t NOP = '{1'b0, 1'b0, 7'h00, 5'd0, 16'h0000};

    bundle_packer dut (
        .clock_i(clock), .reset_n_i(reset_n),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .isBranch_i(is_branch), .instructionFormat_i(fmt),
        .opcode_i(opcode), .reg_i(rg), .operand_i(operand),
        .flush_i(flush), .bundle_o(bundle), .bundle_valid_o(bundle_valid),
        .bundle_ready_i(bundle_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [59:0] ref_bundle(input ins_t a, input ins_t b);
        logic [59:0] r;
        logic [15:0] bo;
        r  = '0;
        bo = b.f ? b.opnd : {11'd0, b.opnd[4:0]};
        r[59] = a.f; r[58] = a.br; r[57:51] = a.op; r[50:46] = a.rg;
        if (a.f) begin
            r[45:30] = a.opnd;
            r[29] = b.f; r[28] = b.br; r[27:21] = b.op; r[20:16] = b.rg; r[15:0] = bo;
        end else begin
            r[45:41] = a.opnd[4:0];
            r[40] = b.f; r[39] = b.br; r[38:32] = b.op; r[31:27] = b.rg; r[26:11] = bo;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset_n && bundle_valid && bundle_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_bundle: got %h want none", bundle);
            end else begin
                e = sb.pop_front();
                chk("bundle", bundle, e.b);
                if (e.c >= 0) chk("bundle_cycle", cyc, e.c);
            end
        end
    end

    task automatic push(input logic [59:0] b, input int c);
        exp_t e;
        e.b = b;
        e.c = c;
        sb.push_back(e);
    endtask

    task automatic drive(input ins_t i);
        fmt = i.f; is_branch = i.br; opcode = i.op; rg = i.rg; operand = i.opnd;
        instr_valid = 1'b1;
    endtask

    // Entered and left at posedge+1; returns once the instruction was accepted.
    task automatic send(input ins_t i);
        logic r;
        int n;
        n = 0;
        drive(i);
        do begin
            @(negedge clock);
            r = instr_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!r && n < 20);
        instr_valid = 1'b0;
        if (!r) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        ins_t a, b, c, d, i, j, l, m, q, r;
        ins_t s[4];
        ins_t k[4];
        int t0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", bundle_valid, 0);
        chk("rst_bundle", bundle, 0);
        chk("rst_ready", instr_ready, 1);
        reset_n = 1'b1;
        idle(1);

        // Slot-1 fmt1 layout, then slot-1 fmt0 layout (hand-computed)
        a = '{1'b1, 1'b0, 7'h12, 5'd3, 16'hBEEF};
        b = '{1'b0, 1'b1, 7'h05, 5'd7, 16'h0009};
        send(a); send(b);
        push(60'h890EFBBD0A70009, cyc);
        drain();
        c = '{1'b0, 1'b0, 7'h01, 5'd2, 16'h0004};
        d = '{1'b1, 1'b0, 7'h7F, 5'd31, 16'h1234};
        send(c); send(d);
        push(60'h008897FF891A000, cyc);
        drain();

        // Back-to-back stream with masked format-0 operands
        s[0] = '{1'b0, 1'b0, 7'h2A, 5'd9, 16'hFFE9};
        s[1] = '{1'b0, 1'b0, 7'h15, 5'd0, 16'h7FF3};
        s[2] = '{1'b1, 1'b0, 7'h60, 5'd30, 16'h8001};
        s[3] = '{1'b0, 1'b1, 7'h0C, 5'd4, 16'hABCD};
        for (int n = 0; n < 4; n++) begin
            drive(s[n]);
            @(negedge clock);
            chk("stream_ready", instr_ready, 1);
            @(posedge clock);
            #1;
            if (n % 2 == 1) push(ref_bundle(s[n-1], s[n]), cyc);
        end
        instr_valid = 1'b0;
        drain();

        // Timeout pad after 8 idle cycles
        i = '{1'b1, 1'b0, 7'h33, 5'd5, 16'hA5A5};
        send(i);
        t0 = cyc;
        push(ref_bundle(i, NOP), t0 + 8);
        idle(7);
        @(negedge clock);
        chk("no_early_pad", bundle_valid, 0);
        @(posedge clock);
        #1;
        drain();

        // Flush three cycles in: pad on the following edge
        j = '{1'b0, 1'b0, 7'h11, 5'd6, 16'h0003};
        send(j);
        t0 = cyc;
        idle(3);
        flush = 1'b1;
        push(ref_bundle(j, NOP), t0 + 4);
        idle(1);
        flush = 1'b0;
        drain();

        // Flush while EMPTY does nothing
        flush = 1'b1;
        idle(2);
        flush = 1'b0;
        idle(2);
        chk("flush_empty", bundle_valid, 0);

        // Backpressure: four streamed, first bundle stable, fourth refused
        k[0] = '{1'b1, 1'b0, 7'h01, 5'd1, 16'h1111};
        k[1] = '{1'b1, 1'b0, 7'h02, 5'd2, 16'h2222};
        k[2] = '{1'b0, 1'b0, 7'h03, 5'd3, 16'h0013};
        k[3] = '{1'b1, 1'b1, 7'h04, 5'd4, 16'h4444};
        bundle_ready = 1'b0;
        send(k[0]); send(k[1]);
        push(ref_bundle(k[0], k[1]), -1);
        send(k[2]);
        drive(k[3]);
        repeat (3) begin
            @(negedge clock);
            chk("stall_valid", bundle_valid, 1);
            chk("stall_ready", instr_ready, 0);
            chk("stall_bundle", bundle, ref_bundle(k[0], k[1]));
        end
        push(ref_bundle(k[2], k[3]), -1);
        @(posedge clock);
        #1;
        bundle_ready = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        drain();

        // Branch from EMPTY
        l = '{1'b0, 1'b1, 7'h40, 5'd1, 16'h0003};
        m = '{1'b1, 1'b0, 7'h22, 5'd8, 16'h5A5A};
`ifdef BUNDLE_BRANCH_CLOSE_EN
        send(l);
        push(ref_bundle(l, NOP), cyc);
        send(m);
        flush = 1'b1;
        push(ref_bundle(m, NOP), cyc + 1);
        idle(1);
        flush = 1'b0;
`else
        send(l);
        @(negedge clock);
        chk("branch_held", bundle_valid, 0);
        @(posedge clock);
        #1;
        send(m);
        push(ref_bundle(l, m), cyc);
`endif
        drain();

        // Reset mid-HALF
        send(i);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_half_valid", bundle_valid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(12);
        chk("rst_half_stale", bundle_valid, 0);

        // Reset mid-OUT
        bundle_ready = 1'b0;
        send(a); send(b);
        @(negedge clock);
        chk("out_before_rst", bundle_valid, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", bundle_valid, 0);
        chk("rst_out_bundle", bundle, 0);
        @(negedge clock);
        reset_n = 1'b1;
        bundle_ready = 1'b1;
        idle(12);
        chk("rst_out_stale", bundle_valid, 0);

        // Normal pairing after reset
        q = '{1'b0, 1'b0, 7'h55, 5'd17, 16'h001E};
        r = '{1'b0, 1'b0, 7'h66, 5'd18, 16'h00F1};
        send(q); send(r);
        push(ref_bundle(q, r), cyc);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
